// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package regfile_arb_pkg;

    typedef enum logic [0:0] {ARB, LOCKED} arb_state_e;

    localparam logic [3:0]  REG_ZERO = 4'd0;
    localparam int unsigned ID_W     = 2;

    // Increment modulo the live requester count rather than modulo 2**ID_W.
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] ptr,
                                                input int unsigned     reqs);
        if (32'(ptr) + 32'd1 >= reqs) begin
            return '0;
        end
        return ptr + ID_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-find-first: grants the first valid bit at or after ptr.
module rr_priority_picker
    import regfile_arb_pkg::*;
#(
    parameter int unsigned REQS = 3
) (
    input  logic [REQS-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [REQS-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = ptr;
        for (int k = 0; k < REQS; k++) begin
            if (!any && valid[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                any       = 1'b1;
            end
            cand = next_ptr(cand, REQS);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with bounded burst locking.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned N        = 24,
    parameter int unsigned REQS     = 3,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQS-1:0]   req_valid,
    input  logic [REQS-1:0]   req_lock,
    input  logic [4*REQS-1:0] req_dest,
    input  logic [N*REQS-1:0] req_data,
    output logic [REQS-1:0]   req_ready,
    output logic              reg_write_en,
    output logic [3:0]        reg_write_dest,
    output logic [N-1:0]      reg_write_data,
    output logic [ID_W-1:0]   grant_id,
    output logic              locked
);

    localparam int unsigned      CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             write_en_q;
    logic [3:0]       write_dest_q;
    logic [N-1:0]     write_data_q;
    logic [ID_W-1:0]  grant_id_q;
    logic             locked_q;

    logic [REQS-1:0]  pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [REQS-1:0]  owner_mask;

    logic             accept;
    logic [ID_W-1:0]  acc_idx;
    logic [3:0]       acc_dest;
    logic [N-1:0]     acc_data;
    logic             acc_lock;

    rr_priority_picker #(
        .REQS (REQS)
    ) u_picker (
        .valid   (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign owner_mask = REQS'(1) << owner_q;

    // Ready is a function of state, pointer, owner and valid only.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        acc_idx   = owner_q;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    req_ready = pick_gnt;
                    accept    = pick_any;
                    acc_idx   = pick_idx;
                end
                LOCKED: begin
                    req_ready = req_valid & owner_mask;
                    accept    = req_valid[owner_q];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_dest = '0;
        acc_data = '0;
        acc_lock = 1'b0;
        for (int i = 0; i < REQS; i++) begin
            if (acc_idx == ID_W'(i)) begin
                acc_dest = req_dest[4*i +: 4];
                acc_data = req_data[N*i +: N];
                acc_lock = req_lock[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            unique case (state_q)
                ARB: begin
                    rr_ptr_d = next_ptr(acc_idx, REQS);
                    if (acc_lock && (LOCK_MAX > 1)) begin
                        state_d    = LOCKED;
                        owner_d    = acc_idx;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    // Release on an unlocked beat or once the burst budget is spent.
                    if (!acc_lock || (beat_cnt_q == CNT_LAST)) begin
                        state_d    = ARB;
                        rr_ptr_d   = next_ptr(owner_q, REQS);
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_q   <= 1'b0;
            write_dest_q <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
            locked_q     <= 1'b0;
        end else begin
            // Zero-register beats are consumed but never reach the file.
            write_en_q <= accept && (acc_dest != REG_ZERO);
            locked_q   <= (state_d == LOCKED);
            if (accept) begin
                write_dest_q <= acc_dest;
                write_data_q <= acc_data;
                grant_id_q   <= acc_idx;
            end
        end
    end

    assign reg_write_en   = write_en_q;
    assign reg_write_dest = write_dest_q;
    assign reg_write_data = write_data_q;
    assign grant_id       = grant_id_q;
    assign locked         = locked_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, round-robin, zero drop, bursts, lock limit.
module tb_regfile_write_arbiter;

    localparam int unsigned N        = 24;
    localparam int unsigned REQS     = 3;
    localparam int unsigned LOCK_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [REQS-1:0]   req_valid;
    logic [REQS-1:0]   req_lock;
    logic [4*REQS-1:0] req_dest;
    logic [N*REQS-1:0] req_data;
    logic [REQS-1:0]   req_ready;
    logic              reg_write_en;
    logic [3:0]        reg_write_dest;
    logic [N-1:0]      reg_write_data;
    logic [1:0]        grant_id;
    logic              locked;

    logic [3:0]   dest_v [REQS];
    logic [N-1:0] data_v [REQS];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < REQS; g++) begin : g_pack
        assign req_dest[4*g +: 4] = dest_v[g];
        assign req_data[N*g +: N] = data_v[g];
    end

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .N        (N),
        .REQS     (REQS),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_lock       (req_lock),
        .req_dest       (req_dest),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .grant_id       (grant_id),
        .locked         (locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic [3:0] dest,
                             input logic [N-1:0] data, input logic [1:0] gid, input logic lk);
        check({tag, ".en"},     32'(reg_write_en),   32'(en));
        check({tag, ".dest"},   32'(reg_write_dest), 32'(dest));
        check({tag, ".data"},   32'(reg_write_data), 32'(data));
        check({tag, ".gid"},    32'(grant_id),       32'(gid));
        check({tag, ".locked"}, 32'(locked),         32'(lk));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        for (int i = 0; i < REQS; i++) begin
            dest_v[i] = 4'(4 + i);
            data_v[i] = 24'h111 * N'(i + 1);
        end

        // Reset: no ready even with valids high.
        cyc();
        cyc();
        req_valid = 3'b111;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        cyc();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check_out("reset", 1'b0, 4'd0, 24'h0, 2'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            check_out("idle", 1'b0, 4'd0, 24'h0, 2'd0, 1'b0);
        end

        // Round-robin with all three valid.
        cyc();
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1) << (k % 3));
            if (k > 0) begin
                check_out("rr_out", 1'b1, 4'(4 + (k - 1) % 3), 24'h111 * N'((k - 1) % 3 + 1),
                          2'((k - 1) % 3), 1'b0);
            end
            cyc();
        end
        req_valid = '0;
        #1;
        check("rr_idle_ready", 32'(req_ready), 32'h0);
        check_out("rr_last", 1'b1, 4'd4, 24'h111, 2'd0, 1'b0);
        cyc();
        check_out("rr_hold", 1'b0, 4'd4, 24'h111, 2'd0, 1'b0);

        // Zero-register drop: accepted, not written, pointer still advances.
        dest_v[0] = 4'd0;
        data_v[0] = 24'hABCDE;
        req_valid = 3'b001;
        #1;
        check("zero_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        #1;
        check("zero_en", 32'(reg_write_en), 32'h0);
        check("zero_gid", 32'(grant_id), 32'h0);
        cyc();
        dest_v[0] = 4'd4;
        data_v[0] = 24'h111;
        req_valid = 3'b111;
        #1;
        check("zero_ptr", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        #1;
        check_out("zero_next", 1'b1, 4'd5, 24'h222, 2'd1, 1'b0);

        // Lock burst from requester 1 (pointer first brought to 1).
        cyc();
        req_valid = 3'b001;
        #1;
        check("burst_prep", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 3'b111;
        req_lock  = 3'b010;
        dest_v[1] = 4'd8;
        #1;
        check("burst0_ready", 32'(req_ready), 32'h2);
        check_out("burst_prep_out", 1'b1, 4'd4, 24'h111, 2'd0, 1'b0);
        cyc();
        dest_v[1] = 4'd9;
        #1;
        check("burst1_ready", 32'(req_ready), 32'h2);
        check_out("burst1_out", 1'b1, 4'd8, 24'h222, 2'd1, 1'b1);
        cyc();
        dest_v[1] = 4'd10;
        req_lock  = 3'b000;
        #1;
        check("burst2_ready", 32'(req_ready), 32'h2);
        check_out("burst2_out", 1'b1, 4'd9, 24'h222, 2'd1, 1'b1);
        cyc();
        #1;
        check("burst_exit_ready", 32'(req_ready), 32'h4);
        check_out("burst3_out", 1'b1, 4'd10, 24'h222, 2'd1, 1'b0);
        cyc();
        req_valid = '0;
        #1;
        check_out("burst_after", 1'b1, 4'd6, 24'h333, 2'd2, 1'b0);

        // Lock limit: requester 0 holds lock permanently; released after LOCK_MAX beats.
        cyc();
        dest_v[0] = 4'd7;
        dest_v[1] = 4'd5;
        req_lock  = 3'b001;
        req_valid = 3'b111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("lmax_ready", 32'(req_ready), 32'h1);
            check("lmax_locked", 32'(locked), 32'(k >= 1));
            if (k >= 1) begin
                check("lmax_dest", 32'(reg_write_dest), 32'd7);
            end
            cyc();
        end
        #1;
        check("lmax_rr1", 32'(req_ready), 32'h2);
        check_out("lmax_out1", 1'b1, 4'd7, 24'h111, 2'd0, 1'b0);
        cyc();
        #1;
        check("lmax_rr2", 32'(req_ready), 32'h4);
        check_out("lmax_out2", 1'b1, 4'd5, 24'h222, 2'd1, 1'b0);
        cyc();
        #1;
        check("lmax_back", 32'(req_ready), 32'h1);
        check_out("lmax_out3", 1'b1, 4'd6, 24'h333, 2'd2, 1'b0);

        // Reset during the second LOCKED beat.
        cyc();
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(req_ready), 32'h0);
        check_out("midrst_pre", 1'b1, 4'd7, 24'h111, 2'd0, 1'b1);
        cyc();
        rst      = 1'b0;
        req_lock = '0;
        #1;
        check_out("post_rst", 1'b0, 4'd0, 24'h0, 2'd0, 1'b0);
        check("post_rst_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        #1;
        check_out("first_after_rst", 1'b1, 4'd7, 24'h111, 2'd0, 1'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
